// File: rtl/i2c_mst_single_byte.sv
// Single-byte I2C master: START, addr+R/W, ACK, one data byte, ACK/NACK, STOP, then a bus-free gap.
// Accept to o_done: 1 + 80 quarters + NUM_CLKS_T_BUF cycles (44 quarters on address NACK); i_start ignored while busy.
module i2c_mst_single_byte #(
  parameter int CLKS_PER_QTR   = 16,
  parameter int WIDTH_QTR      = 8,
  parameter int NUM_CLKS_T_BUF = 96,
  parameter int WIDTH_T_BUF    = 8
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_start,
  input  logic       i_rnw,
  input  logic [6:0] i_addr,
  input  logic [7:0] i_wdata,
  input  logic       i_sda,
  output logic       o_scl,
  output logic       o_sda,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_rdata,
  output logic       o_nack
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_ACK_A, S_DATA, S_ACK_D, S_STOP, S_BUF
  } state_t;

  localparam logic [WIDTH_QTR-1:0]   QTR_LAST = WIDTH_QTR'(CLKS_PER_QTR - 1);
  localparam logic [WIDTH_T_BUF-1:0] BUF_LAST = WIDTH_T_BUF'(NUM_CLKS_T_BUF - 1);

  state_t                 state, state_nxt;
  logic                   rst_meta, rst_n;
  logic [WIDTH_QTR-1:0]   qcnt;
  logic [1:0]             q, q_nxt;
  logic [2:0]             bitcnt;
  logic [7:0]             shreg, wdata_r, rx;
  logic                   rnw_r, sda_smp;
  logic [WIDTH_T_BUF-1:0] bufcnt;
  logic                   scl_nxt, sda_nxt;
  logic                   active, tick, slot_end, accept, buf_done;

  // Reset asserts immediately and releases synchronously.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
    end
  end

  assign active   = (state != S_IDLE) && (state != S_BUF);
  assign tick     = active && (qcnt == QTR_LAST);
  assign slot_end = tick && (q == 2'd3);
  assign accept   = (state == S_IDLE) && i_start;
  assign buf_done = (state == S_BUF) && (bufcnt == BUF_LAST);
  assign q_nxt    = q + 2'd1;

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    scl_nxt   = o_scl;
    sda_nxt   = o_sda;
    case (state)
      S_IDLE:  if (i_start) state_nxt = S_START;
      S_START: if (slot_end) state_nxt = S_ADDR;
      S_ADDR:  if (slot_end && bitcnt == 3'd7) state_nxt = S_ACK_A;
      S_ACK_A: if (slot_end) state_nxt = sda_smp ? S_STOP : S_DATA;
      S_DATA:  if (slot_end && bitcnt == 3'd7) state_nxt = S_ACK_D;
      S_ACK_D: if (slot_end) state_nxt = S_STOP;
      S_STOP:  if (slot_end) state_nxt = S_BUF;
      S_BUF:   if (bufcnt == BUF_LAST) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Line values for the quarter about to begin; SDA data moves only at q1.
    if (tick) begin
      case (state_nxt)
        S_START: begin
          scl_nxt = 1'b1;
          sda_nxt = ~q_nxt[1];
        end
        S_ADDR, S_DATA: begin
          scl_nxt = q_nxt[1];
          if (q_nxt == 2'd1) sda_nxt = (state_nxt == S_DATA && rnw_r) ? 1'b1 : shreg[7];
        end
        S_ACK_A, S_ACK_D: begin
          scl_nxt = q_nxt[1];
          if (q_nxt == 2'd1) sda_nxt = 1'b1;
        end
        S_STOP: begin
          scl_nxt = q_nxt[1];
          sda_nxt = (q_nxt == 2'd3);
        end
        default: begin
          scl_nxt = 1'b1;
          sda_nxt = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      qcnt    <= '0;
      q       <= 2'd0;
      bitcnt  <= 3'd0;
      shreg   <= 8'h00;
      wdata_r <= 8'h00;
      rx      <= 8'h00;
      rnw_r   <= 1'b0;
      sda_smp <= 1'b1;
      bufcnt  <= '0;
      o_scl   <= 1'b1;
      o_sda   <= 1'b1;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_rdata <= 8'h00;
      o_nack  <= 1'b0;
    end else begin
      o_done <= buf_done;
      o_scl  <= scl_nxt;
      o_sda  <= sda_nxt;
      bufcnt <= (state == S_BUF && !buf_done) ? bufcnt + WIDTH_T_BUF'(1) : '0;
      if (accept) begin
        shreg   <= {i_addr, i_rnw};
        wdata_r <= i_wdata;
        rnw_r   <= i_rnw;
        o_nack  <= 1'b0;
        o_busy  <= 1'b1;
        qcnt    <= '0;
        q       <= 2'd0;
        bitcnt  <= 3'd0;
      end
      if (active) begin
        qcnt <= tick ? '0 : qcnt + WIDTH_QTR'(1);
        if (tick) q <= q_nxt;
        // Sample on the last cycle of q2, well inside SCL high.
        if (tick && q == 2'd2) begin
          sda_smp <= i_sda;
          if (state == S_DATA) rx <= {rx[6:0], i_sda};
        end
        if (slot_end) begin
          case (state)
            S_ADDR: begin
              bitcnt <= bitcnt + 3'd1;
              shreg  <= (bitcnt == 3'd7) ? wdata_r : {shreg[6:0], 1'b0};
            end
            S_DATA: begin
              bitcnt <= bitcnt + 3'd1;
              shreg  <= {shreg[6:0], 1'b0};
            end
            S_ACK_A: if (sda_smp) o_nack <= 1'b1;
            S_ACK_D: if (!rnw_r && sda_smp) o_nack <= 1'b1;
            default: ;
          endcase
        end
      end
      if (buf_done) begin
        o_busy <= 1'b0;
        // Read NACK in ACK_D is our own, so o_nack here only reflects the address phase.
        if (rnw_r && !o_nack) o_rdata <= rx;
      end
    end
  end

endmodule

// File: tb/tb_i2c_mst_single_byte.sv
// Directed bench for i2c_mst_single_byte with a behavioural slave at address 0x2A and a bus monitor.
module tb_i2c_mst_single_byte;
  localparam int CLKS_PER_QTR   = 16;
  localparam int WIDTH_QTR      = 8;
  localparam int NUM_CLKS_T_BUF = 96;
  localparam int WIDTH_T_BUF    = 8;
  localparam logic [6:0] SLV_ADDR = 7'h2A;

  logic       i_clk = 1'b0;
  logic       i_rstn = 1'b1;
  logic       i_start = 1'b0;
  logic       i_rnw = 1'b0;
  logic [6:0] i_addr = 7'h00;
  logic [7:0] i_wdata = 8'h00;
  logic       i_sda;
  logic       o_scl, o_sda, o_busy, o_done, o_nack;
  logic [7:0] o_rdata;

  int checks = 0;
  int errors = 0;

  // Slave / monitor state
  logic       slv_sda = 1'b1;
  logic [7:0] slv_i_data = 8'h3C;
  logic       slv_nack_data = 1'b0;
  logic [7:0] slv_o_data = 8'h00;
  logic [7:0] sr = 8'h00;
  logic       match = 1'b0, rd = 1'b0, ack_d_sda = 1'b0;
  logic       scl_p = 1'b1, sda_p = 1'b1, mon_sda, bus_act = 1'b0;
  int rises = 0, falls = 0, starts = 0, stops = 0, cyc = 0;
  int last_start = 0, last_stop = 0, hi_run = 0, hi_max = 0;

  assign i_sda = o_sda & slv_sda;

  always #5 i_clk = ~i_clk;

  i2c_mst_single_byte #(
    .CLKS_PER_QTR(CLKS_PER_QTR), .WIDTH_QTR(WIDTH_QTR),
    .NUM_CLKS_T_BUF(NUM_CLKS_T_BUF), .WIDTH_T_BUF(WIDTH_T_BUF)
  ) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_rnw(i_rnw),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_sda(i_sda),
    .o_scl(o_scl), .o_sda(o_sda), .o_busy(o_busy), .o_done(o_done),
    .o_rdata(o_rdata), .o_nack(o_nack)
  );

  // Slave model plus START/STOP and SCL-high monitor, evaluated away from the active edge.
  always @(negedge i_clk) begin
    mon_sda = i_sda;
    cyc++;
    if (!i_rstn) bus_act = 1'b0;
    if (o_scl && scl_p && sda_p && !mon_sda) begin
      starts++; last_start = cyc; bus_act = 1'b1;
      rises = 0; falls = 0; slv_sda = 1'b1; ack_d_sda = 1'b0;
    end else if (o_scl && scl_p && !sda_p && mon_sda) begin
      stops++; last_stop = cyc; bus_act = 1'b0; slv_sda = 1'b1;
    end else if (o_scl && !scl_p) begin
      rises++;
      if (rises <= 8 || (rises >= 10 && rises <= 17 && match && !rd)) sr = {sr[6:0], mon_sda};
      if (rises == 18) ack_d_sda = mon_sda;
    end else if (!o_scl && scl_p) begin
      falls++;
      if (falls == 9) begin
        match = (sr[7:1] == SLV_ADDR); rd = sr[0]; slv_sda = !match;
      end else if (falls >= 10 && falls <= 17) begin
        slv_sda = (match && rd) ? slv_i_data[3'(17 - falls)] : 1'b1;
      end else if (falls == 18) begin
        if (match && !rd) begin
          slv_sda = slv_nack_data;
          if (!slv_nack_data) slv_o_data = sr;
        end else slv_sda = 1'b1;
      end else slv_sda = 1'b1;
    end
    if (bus_act && o_scl) hi_run++;
    else hi_run = 0;
    if (hi_run > hi_max) hi_max = hi_run;
    scl_p = o_scl; sda_p = mon_sda;
  end

  // Called at a negedge; returns at the negedge of the cycle after accept.
  task automatic launch(input logic rnw, input logic [6:0] addr, input logic [7:0] wd);
    i_rnw = rnw; i_addr = addr; i_wdata = wd; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (o_done !== 1'b1 && n < 3000) begin
      @(negedge i_clk);
      n++;
    end
  endtask

  task automatic test_reset;
    #3 i_rstn = 1'b0;
    repeat (3) @(negedge i_clk);
    checks++; if (o_scl !== 1'b1) begin errors++; $display("FAIL rst_scl got %b exp 1", o_scl); end
    checks++; if (o_sda !== 1'b1) begin errors++; $display("FAIL rst_sda got %b exp 1", o_sda); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", o_busy); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", o_done); end
    checks++; if (o_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata got %h exp 00", o_rdata); end
    checks++; if (o_nack !== 1'b0) begin errors++; $display("FAIL rst_nack got %b exp 0", o_nack); end
    i_rstn = 1'b1;
    repeat (5) @(negedge i_clk);
  endtask

  task automatic test_write;
    int lat, s0, p0;
    s0 = starts; p0 = stops;
    launch(1'b0, 7'h2A, 8'hA5);
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL wr_busy_rise got %b exp 1", o_busy); end
    wait_done(lat);
    checks++; if (lat != 1377) begin errors++; $display("FAIL wr_latency got %0d exp 1377", lat); end
    checks++; if (o_nack !== 1'b0) begin errors++; $display("FAIL wr_nack got %b exp 0", o_nack); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL wr_busy_done got %b exp 0", o_busy); end
    checks++; if (slv_o_data !== 8'hA5) begin errors++; $display("FAIL wr_slave_data got %h exp a5", slv_o_data); end
    checks++; if (starts - s0 != 1 || stops - p0 != 1) begin
      errors++; $display("FAIL wr_start_stop got %0d/%0d exp 1/1", starts - s0, stops - p0);
    end
    @(negedge i_clk);
  endtask

  task automatic test_read;
    int lat;
    launch(1'b1, 7'h2A, 8'h00);
    wait_done(lat);
    checks++; if (lat != 1377) begin errors++; $display("FAIL rd_latency got %0d exp 1377", lat); end
    checks++; if (o_rdata !== 8'h3C) begin errors++; $display("FAIL rd_data got %h exp 3c", o_rdata); end
    checks++; if (o_nack !== 1'b0) begin errors++; $display("FAIL rd_nack got %b exp 0", o_nack); end
    checks++; if (ack_d_sda !== 1'b1) begin errors++; $display("FAIL rd_master_nack got %b exp 1", ack_d_sda); end
    @(negedge i_clk);
  endtask

  task automatic test_addr_nack;
    int lat;
    launch(1'b0, 7'h2B, 8'h11);
    wait_done(lat);
    checks++; if (lat != 801) begin errors++; $display("FAIL anw_latency got %0d exp 801", lat); end
    checks++; if (o_nack !== 1'b1) begin errors++; $display("FAIL anw_nack got %b exp 1", o_nack); end
    checks++; if (slv_o_data !== 8'hA5) begin errors++; $display("FAIL anw_slave_data got %h exp a5", slv_o_data); end
    @(negedge i_clk);
    launch(1'b1, 7'h2B, 8'h00);
    wait_done(lat);
    checks++; if (lat != 801) begin errors++; $display("FAIL anr_latency got %0d exp 801", lat); end
    checks++; if (o_nack !== 1'b1) begin errors++; $display("FAIL anr_nack got %b exp 1", o_nack); end
    checks++; if (o_rdata !== 8'h3C) begin errors++; $display("FAIL anr_rdata got %h exp 3c", o_rdata); end
    @(negedge i_clk);
  endtask

  task automatic test_data_nack;
    int lat;
    slv_nack_data = 1'b1;
    launch(1'b0, 7'h2A, 8'h5A);
    wait_done(lat);
    checks++; if (lat != 1377) begin errors++; $display("FAIL dn_latency got %0d exp 1377", lat); end
    checks++; if (o_nack !== 1'b1) begin errors++; $display("FAIL dn_nack got %b exp 1", o_nack); end
    slv_nack_data = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_back_to_back;
    int n, lat, stop1;
    launch(1'b0, 7'h2A, 8'h66);
    checks++; if (o_nack !== 1'b0) begin errors++; $display("FAIL b2b_nack_clear got %b exp 0", o_nack); end
    n = 1;
    while (o_done !== 1'b1 && n < 3000) begin
      @(negedge i_clk);
      n++;
      if (n == 300) begin
        i_start = 1'b1; i_addr = 7'h2B; i_wdata = 8'hFF;
      end else if (n == 301) i_start = 1'b0;
    end
    checks++; if (n != 1377) begin errors++; $display("FAIL b2b_ignored_latency got %0d exp 1377", n); end
    checks++; if (slv_o_data !== 8'h66) begin errors++; $display("FAIL b2b_data1 got %h exp 66", slv_o_data); end
    stop1 = last_stop;
    launch(1'b0, 7'h2A, 8'h77);
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_in_done got %b exp 1", o_busy); end
    wait_done(lat);
    checks++; if (lat != 1377) begin errors++; $display("FAIL b2b_latency2 got %0d exp 1377", lat); end
    checks++; if (slv_o_data !== 8'h77) begin errors++; $display("FAIL b2b_data2 got %h exp 77", slv_o_data); end
    checks++; if (last_start - stop1 < NUM_CLKS_T_BUF) begin
      errors++; $display("FAIL b2b_bus_free got %0d exp >= %0d", last_start - stop1, NUM_CLKS_T_BUF);
    end
    @(negedge i_clk);
  endtask

  task automatic test_reset_mid;
    int lat;
    launch(1'b0, 7'h2A, 8'h0F);
    // Cycle 800 is q1 of data bit 5 (a 0): SCL and SDA both low.
    for (int n = 1; n < 800; n++) @(negedge i_clk);
    checks++; if (o_scl !== 1'b0 || o_sda !== 1'b0) begin
      errors++; $display("FAIL mid_pre_lines got %b%b exp 00", o_scl, o_sda);
    end
    i_rstn = 1'b0;
    #1;
    checks++; if (o_scl !== 1'b1 || o_sda !== 1'b1) begin
      errors++; $display("FAIL mid_rst_lines got %b%b exp 11", o_scl, o_sda);
    end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b exp 0", o_busy); end
    checks++; if (o_nack !== 1'b0) begin errors++; $display("FAIL mid_rst_nack got %b exp 0", o_nack); end
    repeat (4) @(negedge i_clk);
    i_rstn = 1'b1;
    repeat (900) @(negedge i_clk);
    launch(1'b0, 7'h2A, 8'h5C);
    wait_done(lat);
    checks++; if (lat != 1377) begin errors++; $display("FAIL mid_next_latency got %0d exp 1377", lat); end
    checks++; if (o_nack !== 1'b0 || slv_o_data !== 8'h5C) begin
      errors++; $display("FAIL mid_next_result got nack %b data %h exp nack 0 data 5c", o_nack, slv_o_data);
    end
    @(negedge i_clk);
  endtask

  task automatic test_monitor;
    checks++; if (hi_max < 1 || hi_max > 3 * CLKS_PER_QTR) begin
      errors++; $display("FAIL mon_scl_high got %0d exp 1..%0d", hi_max, 3 * CLKS_PER_QTR);
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_addr_nack;
    test_data_nack;
    test_back_to_back;
    test_reset_mid;
    test_monitor;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
